mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have inputs from the EX/MEM register: t_mem_pc 32, t_mem_reg_addr 5, t_mem_control 8, t_mem_ALU_result 32 (effective address), t_mem_write_data 32.
REQ-004 SHALL decode t_mem_control bits as follows: [0] reg_write, [1] r_type, [2] mem_read, [3] mem_write, [4] mem_to_reg, [7:5] funct3.
REQ-005 SHALL have data-memory bus ports: dmem_req out 1, dmem_we out 1, dmem_addr out 32 (word-aligned, [1:0]=0), dmem_be out 4, dmem_wdata out 32, dmem_rdata in 32, dmem_ready in 1.
REQ-006 SHALL have outputs to the MEM/WB register: t_wb_pc 32, t_wb_reg_addr 5, t_wb_reg_write 1, t_wb_data 32, t_wb_valid 1.
REQ-007 SHALL have status outputs: mem_stall out 1 (freezes PC and upstream pipeline registers), misalign_err out 1, bus_err out 1.

Function
REQ-008 SHALL use FSM states IDLE and ACCESS.
REQ-009 In IDLE with neither mem_read nor mem_write set, SHALL register the inputs to the t_wb_* outputs after 1 cycle, with t_wb_data=ALU_result, t_wb_valid=1, and mem_stall=0.
REQ-010 In IDLE with an aligned load or store, SHALL capture the operands, enter ACCESS next cycle, and hold mem_stall=1 combinationally from the capture cycle until the cycle dmem_ready is seen.
REQ-011 In ACCESS, SHALL hold dmem_req=1 and keep addr/be/we/wdata stable until dmem_ready=1.
REQ-012 On dmem_ready in ACCESS, SHALL deassert dmem_req next cycle, return to IDLE, and present the result on t_wb_* with t_wb_valid=1 for exactly one cycle.
REQ-013 SHALL treat alignment as: LW/SW need addr[1:0]=00; LH/LHU/SH need addr[0]=0; byte ops are always aligned.
REQ-014 On a misaligned access, SHALL issue no dmem_req, pulse misalign_err for 1 cycle, set t_wb_valid=1 with t_wb_reg_write=0, and not stall.
REQ-015 SHALL drive store byte enables as: SB be=0001<<addr[1:0], wdata = byte replicated x4; SH be=0011<<(2*addr[1]), wdata = half replicated x2; SW be=1111.
REQ-016 For loads, SHALL drive be=1111 and dmem_we=0, then extract the lane selected by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through; undefined funct3 returns 0.
REQ-017 SHALL write back mem data when mem_to_reg=1, else ALU_result; stores SHALL force t_wb_reg_write=0.
REQ-018 SHALL count ACCESS cycles in a 4-bit timeout counter; if dmem_ready has not arrived when the count reaches 15, SHALL abort to IDLE, pulse bus_err for 1 cycle, and emit t_wb_valid=1 with t_wb_reg_write=0.
REQ-019 When dmem_ready arrives in the same cycle the counter reaches 15, SHALL give ready priority: normal completion, no bus_err.
REQ-020 SHALL clear the timeout counter on every ACCESS entry.
REQ-021 While mem_stall=1, SHALL ignore t_mem_* input changes and use only the captured copy.
REQ-022 SHALL hold t_wb_valid=0 in every cycle with no completion.

Reset
REQ-023 When rst=1 at a clock edge, SHALL set state=IDLE, clear the counter, and set every output to 0, including dmem_req, mem_stall, errors and all t_wb_* outputs.
REQ-024 On reset during ACCESS, SHALL drop dmem_req on that same edge and discard the in-flight access with no t_wb_valid.
REQ-025 SHALL decode the first instruction in the cycle after rst falls.

Structure
REQ-026 SHALL place the control bit indices, funct3 load/store encodings, state enum and timeout constant (15) in the shared package mem_stage_pkg.
REQ-027 SHALL implement lane extraction and extension (REQ-016) as the combinational sub-module load_align_ext.
REQ-028 SHALL size the RTL at 150-300 lines.

Verification
REQ-029 ALU op: control=8'h01, ALU_result=32'h0000_0055 -> next cycle t_wb_data=0x55, t_wb_reg_write=1, t_wb_valid=1, mem_stall=0.
REQ-030 LB from addr 0x103, rdata=0x80AA_BBCC, ready after 2 cycles -> dmem_addr=0x100, mem_stall high 3 cycles, t_wb_data=0xFFFF_FF80.
REQ-031 SH of 0x1234_ABCD to addr 0x202 -> dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, t_wb_reg_write=0.
REQ-032 LW at addr 0x101 -> no dmem_req, misalign_err pulse, t_wb_reg_write=0, no stall.
REQ-033 Load with dmem_ready never asserted -> bus_err after 15 ACCESS cycles, dmem_req low next cycle, then ready at exactly count 15 in a rerun -> completion, no bus_err.
REQ-034 rst asserted on the 2nd ACCESS cycle -> dmem_req=0 and all outputs 0 after that edge, no t_wb_valid.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: control-bit indices, funct3 encodings, FSM states, timeout and record types for the memory-access stage
package mem_stage_pkg;
  localparam int CTL_REG_WRITE = 0;
  localparam int CTL_R_TYPE = 1;
  localparam int CTL_MEM_READ = 2;
  localparam int CTL_MEM_WRITE = 3;
  localparam int CTL_MEM_TO_REG = 4;
  localparam logic [2:0] F3_B = 3'd0;
  localparam logic [2:0] F3_H = 3'd1;
  localparam logic [2:0] F3_W = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [3:0] TIMEOUT = 4'd15;
  typedef enum logic {IDLE, ACCESS} state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [3:0]  be;
    logic [2:0]  f3;
    logic        we;
    logic        rw;
    logic        m2r;
  } op_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        valid;
    logic        mis;
    logic        berr;
  } wb_t;
endpackage

// File: rtl/load_align_ext.sv
// load_align_ext: selects the loaded byte/half/word lane and sign- or zero-extends it
module load_align_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [15:0] lane;
  assign lane = 16'(rdata >> {off, 3'b000});
  assign data = funct3 == F3_B  ? {{24{lane[7]}}, lane[7:0]} :
                funct3 == F3_H  ? {{16{lane[15]}}, lane} :
                funct3 == F3_W  ? rdata :
                funct3 == F3_BU ? {24'd0, lane[7:0]} :
                funct3 == F3_HU ? {16'd0, lane} : '0;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage driving a word-addressed data bus with alignment checks, timeout and write-back
module mem_access_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] t_mem_pc,
  input  logic [4:0]  t_mem_reg_addr,
  input  logic [7:0]  t_mem_control,
  input  logic [31:0] t_mem_ALU_result,
  input  logic [31:0] t_mem_write_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] t_wb_pc,
  output logic [4:0]  t_wb_reg_addr,
  output logic        t_wb_reg_write,
  output logic [31:0] t_wb_data,
  output logic        t_wb_valid,
  output logic        mem_stall,
  output logic        misalign_err,
  output logic        bus_err
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  op_t op_q, op_d;
  wb_t wb_q, wb_d;
  logic ld, st, mem_op, mis, idle, access, start, done, timeout, unused_r_type;
  logic [2:0] f3;
  logic [1:0] off;
  logic [31:0] ld_data;
  assign unused_r_type = t_mem_control[CTL_R_TYPE];
  assign ld = t_mem_control[CTL_MEM_READ];
  assign st = t_mem_control[CTL_MEM_WRITE];
  assign mem_op = ld || st;
  assign f3 = t_mem_control[7:5];
  assign off = t_mem_ALU_result[1:0];
  assign mis = (f3[1:0] == 2'd1 && off[0]) || (f3[1:0] == 2'd2 && off != 2'd0);
  assign idle = state_q == IDLE;
  assign access = state_q == ACCESS;
  assign start = idle && mem_op && !mis;
  assign done = access && dmem_ready;
  assign timeout = access && !dmem_ready && cnt_q == TIMEOUT - 4'd1;
  assign mem_stall = !rst && (start || (access && !done && !timeout));
  assign dmem_req = access;
  assign dmem_we = access && op_q.we;
  assign dmem_addr = access ? {op_q.alu[31:2], 2'b00} : '0;
  assign dmem_be = access ? op_q.be : '0;
  assign dmem_wdata = access ? op_q.wdata : '0;
  assign t_wb_pc = wb_q.pc;
  assign t_wb_reg_addr = wb_q.rd;
  assign t_wb_reg_write = wb_q.rw;
  assign t_wb_data = wb_q.data;
  assign t_wb_valid = wb_q.valid;
  assign misalign_err = wb_q.mis;
  assign bus_err = wb_q.berr;
  load_align_ext u_ext (
    .rdata(dmem_rdata),
    .off(op_q.alu[1:0]),
    .funct3(op_q.f3),
    .data(ld_data)
  );
  always_comb begin
    state_d = start ? ACCESS : (done || timeout) ? IDLE : state_q;
    cnt_d = start ? 4'd0 : access ? cnt_q + 4'd1 : cnt_q;
    op_d = op_q;
    if (start) begin
      op_d.pc = t_mem_pc;
      op_d.alu = t_mem_ALU_result;
      op_d.rd = t_mem_reg_addr;
      op_d.f3 = f3;
      op_d.we = st;
      op_d.rw = t_mem_control[CTL_REG_WRITE] && !st;
      op_d.m2r = t_mem_control[CTL_MEM_TO_REG];
      op_d.be = !st ? 4'hf : f3[1:0] == 2'd0 ? 4'b0001 << off : f3[1:0] == 2'd1 ? 4'b0011 << {off[1], 1'b0} : 4'hf;
      op_d.wdata = f3[1:0] == 2'd0 ? {4{t_mem_write_data[7:0]}} : f3[1:0] == 2'd1 ? {2{t_mem_write_data[15:0]}} : t_mem_write_data;
    end
    wb_d = '0;
    if (idle && (!mem_op || mis)) begin
      wb_d.pc = t_mem_pc;
      wb_d.rd = t_mem_reg_addr;
      wb_d.rw = !mem_op && t_mem_control[CTL_REG_WRITE];
      wb_d.data = t_mem_ALU_result;
      wb_d.valid = 1'b1;
      wb_d.mis = mem_op;
    end else if (done || timeout) begin
      wb_d.pc = op_q.pc;
      wb_d.rd = op_q.rd;
      wb_d.rw = done && op_q.rw;
      wb_d.data = (done && op_q.m2r) ? ld_data : op_q.alu;
      wb_d.valid = 1'b1;
      wb_d.berr = timeout;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      wb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      wb_q <= wb_d;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: table-driven, hand-written and randomized checks of mem_access_stage against a behavioural model
module tb_mem_access_stage;
  logic clk = 0, rst = 1;
  logic [31:0] t_mem_pc = 0, t_mem_ALU_result = 0, t_mem_write_data = 0, dmem_rdata = 0;
  logic [4:0] t_mem_reg_addr = 0;
  logic [7:0] t_mem_control = 0;
  logic dmem_ready = 0;
  logic dmem_req, dmem_we, t_wb_reg_write, t_wb_valid, mem_stall, misalign_err, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, t_wb_pc, t_wb_data;
  logic [3:0] dmem_be;
  logic [4:0] t_wb_reg_addr;
  int vectors = 0, miscompares = 0;
  typedef struct packed {
    logic [7:0]  c;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] r;
    logic [4:0]  l;
    logic        iss;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] d;
    logic        rw;
    logic        mis;
  } vec_t;
  vec_t tab [14];
  always #5 clk = ~clk;
  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .t_mem_pc(t_mem_pc), .t_mem_reg_addr(t_mem_reg_addr), .t_mem_control(t_mem_control),
    .t_mem_ALU_result(t_mem_ALU_result), .t_mem_write_data(t_mem_write_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .t_wb_pc(t_wb_pc), .t_wb_reg_addr(t_wb_reg_addr), .t_wb_reg_write(t_wb_reg_write),
    .t_wb_data(t_wb_data), .t_wb_valid(t_wb_valid), .mem_stall(mem_stall),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic void model(input logic [7:0] c, input logic [31:0] a, input logic [31:0] w,
                                input logic [31:0] r, input int l, output logic iss, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] d, output logic rw,
                                output logic mis, output logic berr);
    int sz, off;
    logic [31:0] lane;
    off = int'(a[1:0]);
    sz = (c[6:5] == 2'd1) ? 2 : (c[6:5] == 2'd2) ? 4 : 1;
    mis = (c[2] || c[3]) && (off % sz != 0);
    iss = (c[2] || c[3]) && !mis;
    berr = iss && l >= 15;
    be = c[3] ? ((sz == 4) ? 4'hf : 4'(((sz == 2) ? 3 : 1) << off)) : 4'hf;
    wd = (sz == 1) ? {4{w[7:0]}} : (sz == 2) ? {2{w[15:0]}} : w;
    lane = r >> (8 * off);
    case (c[7:5])
      3'd0: d = 32'($signed(lane[7:0]));
      3'd1: d = 32'($signed(lane[15:0]));
      3'd2: d = r;
      3'd4: d = 32'(lane[7:0]);
      3'd5: d = 32'(lane[15:0]);
      default: d = 0;
    endcase
    if (!(c[2] && !c[3] && c[4] && iss && !berr)) d = a;
    rw = c[0] && !c[3] && !mis && !berr;
  endfunction
  // Called right after a rising edge; returns right after the edge that makes the result visible.
  task automatic do_op(input logic [31:0] pc, input logic [4:0] rd, input logic [7:0] c, input logic [31:0] a,
                       input logic [31:0] w, input logic [31:0] r, input int l, input logic iss,
                       input logic [3:0] be, input logic [31:0] wd, input logic [31:0] d, input logic rw,
                       input logic mis, input logic berr);
    int k;
    t_mem_pc = pc; t_mem_reg_addr = rd; t_mem_control = c; t_mem_ALU_result = a; t_mem_write_data = w;
    dmem_ready = 0;
    @(negedge clk);
    chk("stall_capture", mem_stall, iss);
    chk("req_idle", dmem_req, 0);
    if (iss) begin
      k = 0;
      while (1) begin
        @(posedge clk); #1;
        k++;
        t_mem_pc = $urandom; t_mem_reg_addr = 5'($urandom); t_mem_control = 8'($urandom);
        t_mem_ALU_result = $urandom; t_mem_write_data = $urandom;
        dmem_ready = (k == l + 1);
        dmem_rdata = dmem_ready ? r : $urandom;
        @(negedge clk);
        chk("req_access", dmem_req, 1);
        chk("addr", dmem_addr, {a[31:2], 2'b00});
        chk("be", dmem_be, be);
        chk("we", dmem_we, c[3]);
        if (c[3]) chk("wdata", dmem_wdata, wd);
        chk("stall_access", mem_stall, !dmem_ready && k < 15);
        chk("valid_access", t_wb_valid, 0);
        chk("err_access", {misalign_err, bus_err}, 0);
        if (dmem_ready || k >= 15) break;
      end
    end
    @(posedge clk); #1;
    dmem_ready = 0;
    t_mem_control = 0;
    chk("wb_valid", t_wb_valid, 1);
    chk("wb_rw", t_wb_reg_write, rw);
    chk("wb_pc", t_wb_pc, pc);
    chk("wb_rd", t_wb_reg_addr, rd);
    if (!mis && !berr) chk("wb_data", t_wb_data, d);
    chk("misalign_err", misalign_err, mis);
    chk("bus_err", bus_err, berr);
    chk("req_after", dmem_req, 0);
  endtask
  initial begin
    tab = '{
      '{8'h01, 32'h0000_0055, 32'h0, 32'h0, 5'd0, 1'b0, 4'h0, 32'h0, 32'h0000_0055, 1'b1, 1'b0},
      '{8'h15, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 5'd2, 1'b1, 4'hf, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b0},
      '{8'h29, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 5'd1, 1'b1, 4'hc, 32'hABCD_ABCD, 32'h0000_0202, 1'b0, 1'b0},
      '{8'h55, 32'h0000_0101, 32'h0, 32'h0, 5'd0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1},
      '{8'h95, 32'h0000_0102, 32'h0, 32'h80AA_BBCC, 5'd0, 1'b1, 4'hf, 32'h0, 32'h0000_00AA, 1'b1, 1'b0},
      '{8'h35, 32'h0000_0102, 32'h0, 32'h80AA_BBCC, 5'd3, 1'b1, 4'hf, 32'h0, 32'hFFFF_80AA, 1'b1, 1'b0},
      '{8'hB5, 32'h0000_0100, 32'h0, 32'h80AA_BBCC, 5'd1, 1'b1, 4'hf, 32'h0, 32'h0000_BBCC, 1'b1, 1'b0},
      '{8'h55, 32'h0000_0204, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b1, 4'hf, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0},
      '{8'h08, 32'h0000_0301, 32'h0000_00A5, 32'h0, 5'd0, 1'b1, 4'h2, 32'hA5A5_A5A5, 32'h0000_0301, 1'b0, 1'b0},
      '{8'h48, 32'h0000_0400, 32'hCAFE_F00D, 32'h0, 5'd2, 1'b1, 4'hf, 32'hCAFE_F00D, 32'h0000_0400, 1'b0, 1'b0},
      '{8'h35, 32'h0000_0103, 32'h0, 32'h0, 5'd0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1},
      '{8'h75, 32'h0000_0108, 32'h0, 32'hFFFF_FFFF, 5'd1, 1'b1, 4'hf, 32'h0, 32'h0000_0000, 1'b1, 1'b0},
      '{8'h05, 32'h0000_0100, 32'h0, 32'h1111_2222, 5'd0, 1'b1, 4'hf, 32'h0, 32'h0000_0100, 1'b1, 1'b0},
      '{8'h28, 32'h0000_0201, 32'hFFFF_FFFF, 32'h0, 5'd0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1}
    };
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, t_wb_pc, t_wb_reg_addr,
                              t_wb_reg_write, t_wb_data, t_wb_valid, mem_stall, misalign_err, bus_err} != 0), 0);
    rst = 0;
    for (int i = 0; i < 14; i++)
      do_op(32'h1000 + 32'(4 * i), 5'(i + 1), tab[i].c, tab[i].a, tab[i].w, tab[i].r, int'(tab[i].l),
            tab[i].iss, tab[i].be, tab[i].wd, tab[i].d, tab[i].rw, tab[i].mis, 1'b0);
    do_op(32'h2000, 5'd7, 8'h55, 32'h0000_0800, 32'h0, 32'h1234_5678, 20, 1'b1, 4'hf, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    do_op(32'h2004, 5'd8, 8'h55, 32'h0000_0800, 32'h0, 32'h1234_5678, 14, 1'b1, 4'hf, 32'h0, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    t_mem_pc = 32'h3000; t_mem_reg_addr = 5'd9; t_mem_control = 8'h55; t_mem_ALU_result = 32'h500;
    @(posedge clk); #1;
    t_mem_control = 0;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("req_before_rst", dmem_req, 1);
    @(posedge clk); #1;
    chk("rst_access_outputs", 32'({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, t_wb_pc, t_wb_reg_addr,
                                   t_wb_reg_write, t_wb_data, mem_stall, misalign_err, bus_err} != 0), 0);
    chk("rst_access_valid", t_wb_valid, 0);
    rst = 0;
    t_mem_control = 8'h01; t_mem_ALU_result = 32'h77; t_mem_pc = 32'h3004; t_mem_reg_addr = 5'd3;
    @(posedge clk); #1;
    chk("first_after_rst_valid", t_wb_valid, 1);
    chk("first_after_rst_data", t_wb_data, 32'h77);
    chk("no_stale_req", dmem_req, 0);
    for (int n = 0; n < 80; n++) begin
      logic [7:0] c;
      logic [31:0] a, w, r, pc, wd, d;
      logic [2:0] f;
      logic [3:0] be;
      logic iss, rw, mis, berr;
      int l, kind;
      kind = $urandom_range(0, 2);
      a = $urandom; w = $urandom; r = $urandom; pc = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      l = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 16) : $urandom_range(0, 4);
      if (kind == 0) c = {3'($urandom), 1'($urandom), 2'b00, 2'($urandom)};
      else if (kind == 1) begin
        f = 3'($urandom_range(0, 5));
        if (f == 3'd3) f = 3'd5;
        c = {f, 1'($urandom), 2'b01, 2'($urandom)};
      end else begin
        f = 3'($urandom_range(0, 2));
        c = {f, 1'b0, 2'b10, 2'($urandom)};
      end
      model(c, a, w, r, l, iss, be, wd, d, rw, mis, berr);
      do_op(pc, 5'($urandom), c, a, w, r, l, iss, be, wd, d, rw, mis, berr);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
